nibble_serial_adder: RTL

Digit-serial WIDTH-bit adder that accepts two operands plus carry-in over a valid/ready handshake and adds them one 4-bit nibble per clock, LSB nibble first. It reuses the team's 4-bit carry-select `adder_cell` as its only arithmetic element and keeps the inter-nibble carry in a flip-flop. It sits directly upstream of the carry-select cell: it sequences operand nibbles into the cell, registers the nibble sums and carry the cell produces, and presents the completed WIDTH-bit result to the downstream consumer.

---
 rtl/nibble_serial_adder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: digit-serial WIDTH-bit adder, one 4-bit nibble per clock, LSB nibble
// first, built around a single 4-bit carry-select adder_cell.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand set on in_a/in_b/in_cin is valid
//   in_ready   block can accept an operand set (IDLE only)
//   in_a/in_b  WIDTH-bit operands
//   in_cin     carry into bit 0
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts the result
//   out_sum    in_a + in_b + in_cin modulo 2^WIDTH
//   out_cout   carry out of bit WIDTH-1
//   out_ovf    two's-complement overflow

// adder_cell: 4-bit carry-select adder; both carry hypotheses are precomputed and the
// incoming carry only drives the final select.
module adder_cell (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);
   logic [4:0] sum_c0;
   logic [4:0] sum_c1;

   always_comb begin
      sum_c0 = {1'b0, a_i} + {1'b0, b_i};
      sum_c1 = {1'b0, a_i} + {1'b0, b_i} + 5'd1;
      {cout_o, sum_o} = cin_i ? sum_c1 : sum_c0;
   end
endmodule

module nibble_serial_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);
   localparam int unsigned Nib  = WIDTH / 4;
   // Keep the counter at least one bit wide so WIDTH=4 still elaborates.
   localparam int unsigned CntW = (Nib > 1) ? $clog2(Nib) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(Nib - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic              carry_q, carry_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              msb_a_q, msb_a_d;
   logic              msb_b_q, msb_b_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;

   logic [3:0]        cell_sum;
   logic              cell_cout;

   adder_cell u_cell (
      .a_i    (a_q[3:0]),
      .b_i    (b_q[3:0]),
      .cin_i  (carry_q),
      .sum_o  (cell_sum),
      .cout_o (cell_cout)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      msb_a_d = msb_a_q;
      msb_b_d = msb_b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               carry_d = in_cin;
               cnt_d   = '0;
               msb_a_d = in_a[WIDTH-1];
               msb_b_d = in_b[WIDTH-1];
               state_d = StRun;
            end
         end
         StRun: begin
            // Only the nibble selected by the counter is overwritten; the rest hold.
            for (int i = 0; i < int'(Nib); i++) begin
               if (cnt_q == CntW'(i)) begin
                  sum_d[4*i +: 4] = cell_sum;
               end
            end
            carry_d = cell_cout;
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
               cnt_d   = '0;
               cout_d  = cell_cout;
               // Last cell sum bit 3 is the result MSB.
               ovf_d   = (msb_a_q == msb_b_q) && (cell_sum[3] != msb_a_q);
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         msb_a_q <= 1'b0;
         msb_b_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         msb_a_q <= msb_a_d;
         msb_b_q <= msb_b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign out_ovf   = ovf_q;
endmodule
